diagv2_test_sequencer: RTL and testbench

Synthesizable campaign controller for the diag-v2 pipelined core. It steps a core under test through NUM_TESTS programs in sequence: it requests an image load, holds the core in reset, runs it, and catches the ECALL. It then grades the a0 status code and keeps pass/fail tallies. It sits beside diagv2_top and drives its reset and run-enable, so regression campaigns can run on FPGA without a simulator.

---
 rtl/diagv2_pkg.sv | 32 +++
 rtl/diagv2_cycle_timer.sv | 40 ++++
 rtl/diagv2_test_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_diagv2_test_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diagv2_pkg.sv
// ---------------------------------------------------------------------------
// diagv2_pkg
//   Shared definitions for the diag-v2 test sequencer:
//     - sequencer state encoding (ST_*), kept as plain 3-bit constants so
//       older tooling and waveform scripts can decode the state register
//     - SEQ_PASS_CODE    : status value that grades a test as passed (0)
//     - SEQ_TIMEOUT_CODE : status reported when the watchdog fires (all ones)
//     - seq_idx_bits()   : width of a test index, never narrower than 1 bit
//   The status constants are declared at the widest supported data width
//   (SEQ_MAX_DATA_BITS); users slice them down to their own DATA_BITS.
// ---------------------------------------------------------------------------
package diagv2_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_LOAD   = 3'd1;
  localparam seq_state_t ST_RESET  = 3'd2;
  localparam seq_state_t ST_RUN    = 3'd3;
  localparam seq_state_t ST_RECORD = 3'd4;
  localparam seq_state_t ST_DONE   = 3'd5;

  localparam int SEQ_MAX_DATA_BITS = 128;

  localparam logic [SEQ_MAX_DATA_BITS-1:0] SEQ_PASS_CODE    = '0;
  localparam logic [SEQ_MAX_DATA_BITS-1:0] SEQ_TIMEOUT_CODE = '1;

  function automatic int seq_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/diagv2_cycle_timer.sv
// ---------------------------------------------------------------------------
// diagv2_cycle_timer
//   Loadable down-counter with a terminal-count flag. The sequencer loads it
//   with (hold length - 1) and watches tc, so a hold of N cycles ends on the
//   Nth enabled cycle. The counter parks at zero rather than wrapping.
//
//   Ports:
//     clk        in   clock
//     reset_n    in   asynchronous active-low reset (count -> 0)
//     load       in   load load_value this cycle (takes priority over enable)
//     load_value in   WIDTH  value to load
//     enable     in   decrement by one when nonzero
//     tc         out  count is zero
// ---------------------------------------------------------------------------
module diagv2_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/diagv2_test_sequencer.sv
// ---------------------------------------------------------------------------
// diagv2_test_sequencer
//   Campaign controller for the diag-v2 core. Walks NUM_TESTS programs:
//   request image load, hold the core in reset for RESET_CYCLES, run it until
//   ECALL, grade a0 (0 = pass), tally, and move to the next program.
//
//   Optional feature macro: DIAGV2_SEQ_TIMEOUT_EN
//     Adds a RUN watchdog of TIMEOUT_CYCLES cycles and the timed_out output.
//     A timed-out test is recorded with result_code = all ones (a fail).
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     start               pulse: begin a campaign (only from IDLE/DONE)
//     ecall, status_code  ECALL retire strobe and a0 value from the core
//     load_req/load_idx   loader request and program index
//     load_done           loader completion
//     core_reset/core_run reset and clock-enable for the core under test
//     test_idx            current program index
//     result_valid        one-cycle pulse per graded test, with result_pass,
//                         result_code (and timed_out when enabled)
//     passed_count/failed_count  running tallies
//     busy, done          campaign in progress / complete
//   All outputs are decoded from registered state and data only.
// ---------------------------------------------------------------------------
module diagv2_test_sequencer
  import diagv2_pkg::*;
#(
  parameter int NUM_TESTS      = 50,
  parameter int DATA_BITS      = 64,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic                                  ecall,
  input  logic [DATA_BITS-1:0]                  status_code,
  output logic                                  load_req,
  output logic [seq_idx_bits(NUM_TESTS)-1:0]    load_idx,
  input  logic                                  load_done,
  output logic                                  core_reset,
  output logic                                  core_run,
  output logic [seq_idx_bits(NUM_TESTS)-1:0]    test_idx,
  output logic                                  result_valid,
  output logic                                  result_pass,
`ifdef DIAGV2_SEQ_TIMEOUT_EN
  output logic                                  timed_out,
`endif
  output logic [DATA_BITS-1:0]                  result_code,
  output logic [$clog2(NUM_TESTS+1)-1:0]        passed_count,
  output logic [$clog2(NUM_TESTS+1)-1:0]        failed_count,
  output logic                                  busy,
  output logic                                  done
);

  localparam int IDX_W = seq_idx_bits(NUM_TESTS);
  localparam int CNT_W = $clog2(NUM_TESTS + 1);

  // One timer serves both the reset hold and the watchdog; it is sized for
  // the longer of the two so its width does not depend on the build option.
  localparam int TIMER_MAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] RESET_LOAD = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_TESTS - 1);
  localparam logic [DATA_BITS-1:0] PASS_CODE = SEQ_PASS_CODE[DATA_BITS-1:0];

  seq_state_t           state_reg, state_next;
  logic [IDX_W-1:0]     test_idx_reg, test_idx_next;
  logic [CNT_W-1:0]     passed_reg, passed_next;
  logic [CNT_W-1:0]     failed_reg, failed_next;
  logic [DATA_BITS-1:0] result_code_reg, result_code_next;

  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_en;
  logic                 timer_tc;

`ifdef DIAGV2_SEQ_TIMEOUT_EN
  localparam logic [TIMER_W-1:0]   TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_BITS-1:0] TIMEOUT_CODE = SEQ_TIMEOUT_CODE[DATA_BITS-1:0];
  logic timed_out_reg, timed_out_next;
`endif

  diagv2_cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .load_value(timer_value),
    .enable    (timer_en),
    .tc        (timer_tc)
  );

  always_comb begin
    state_next       = state_reg;
    test_idx_next    = test_idx_reg;
    passed_next      = passed_reg;
    failed_next      = failed_reg;
    result_code_next = result_code_reg;
    timer_load       = 1'b0;
    timer_value      = RESET_LOAD;
    timer_en         = 1'b0;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
    timed_out_next   = timed_out_reg;
`endif

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next    = ST_LOAD;
          test_idx_next = '0;
          passed_next   = '0;
          failed_next   = '0;
        end
      end

      ST_LOAD: begin
        if (load_done) begin
          state_next = ST_RESET;
          timer_load = 1'b1;
        end
      end

      ST_RESET: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          state_next = ST_RUN;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
          timer_load  = 1'b1;
          timer_value = TIMEOUT_LOAD;
`endif
        end
      end

      ST_RUN: begin
`ifdef DIAGV2_SEQ_TIMEOUT_EN
        timer_en = 1'b1;
`endif
        // A retiring ECALL wins over a watchdog expiring in the same cycle.
        if (ecall) begin
          state_next       = ST_RECORD;
          result_code_next = status_code;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
          timed_out_next   = 1'b0;
        end else if (timer_tc) begin
          state_next       = ST_RECORD;
          result_code_next = TIMEOUT_CODE;
          timed_out_next   = 1'b1;
`endif
        end
      end

      ST_RECORD: begin
        if (result_code_reg == PASS_CODE) begin
          passed_next = passed_reg + 1'b1;
        end else begin
          failed_next = failed_reg + 1'b1;
        end
        if (test_idx_reg == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          state_next    = ST_LOAD;
          test_idx_next = test_idx_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      test_idx_reg    <= '0;
      passed_reg      <= '0;
      failed_reg      <= '0;
      result_code_reg <= '0;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
      timed_out_reg   <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      test_idx_reg    <= test_idx_next;
      passed_reg      <= passed_next;
      failed_reg      <= failed_next;
      result_code_reg <= result_code_next;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
      timed_out_reg   <= timed_out_next;
`endif
    end
  end

  // Moore output decode. The core is held in reset everywhere except while
  // it runs and in the single grading cycle where it is merely halted.
  assign load_req     = (state_reg == ST_LOAD);
  assign core_reset   = !((state_reg == ST_RUN) || (state_reg == ST_RECORD));
  assign core_run     = (state_reg == ST_RESET) || (state_reg == ST_RUN);
  assign result_valid = (state_reg == ST_RECORD);
  assign result_pass  = (state_reg == ST_RECORD) && (result_code_reg == PASS_CODE);
`ifdef DIAGV2_SEQ_TIMEOUT_EN
  assign timed_out    = (state_reg == ST_RECORD) && timed_out_reg;
`endif
  assign result_code  = result_code_reg;
  assign test_idx     = test_idx_reg;
  assign load_idx     = test_idx_reg;
  assign passed_count = passed_reg;
  assign failed_count = failed_reg;
  assign busy         = (state_reg == ST_LOAD) || (state_reg == ST_RESET) ||
                        (state_reg == ST_RUN)  || (state_reg == ST_RECORD);
  assign done         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_diagv2_test_sequencer
//   Directed campaign steps with randomized load delays, run lengths, status
//   codes and stray inputs. Expected values come from a per-test model:
//   fixed latencies (start->LOAD 1, RESET hold RC cycles, ECALL->RECORD 1,
//   RECORD->next 1) and pass/fail tallies computed from the status codes.
//   Build with +define+DIAGV2_SEQ_TIMEOUT_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_diagv2_test_sequencer;

  localparam int NT = 3;
  localparam int DB = 64;
  localparam int RC = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          ecall;
  logic [DB-1:0] status_code;
  logic          load_req;
  logic [1:0]    load_idx;
  logic          load_done;
  logic          core_reset;
  logic          core_run;
  logic [1:0]    test_idx;
  logic          result_valid;
  logic          result_pass;
  logic [DB-1:0] result_code;
  logic [1:0]    passed_count;
  logic [1:0]    failed_count;
  logic          busy;
  logic          done;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
  logic          timed_out;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  diagv2_test_sequencer #(
    .NUM_TESTS     (NT),
    .DATA_BITS     (DB),
    .RESET_CYCLES  (RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .ecall       (ecall),
    .status_code (status_code),
    .load_req    (load_req),
    .load_idx    (load_idx),
    .load_done   (load_done),
    .core_reset  (core_reset),
    .core_run    (core_run),
    .test_idx    (test_idx),
    .result_valid(result_valid),
    .result_pass (result_pass),
`ifdef DIAGV2_SEQ_TIMEOUT_EN
    .timed_out   (timed_out),
`endif
    .result_code (result_code),
    .passed_count(passed_count),
    .failed_count(failed_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_load_req"}, load_req, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result_pass"}, result_pass, 0);
    chk({tag, "_result_code"}, result_code, 0);
    chk({tag, "_test_idx"}, test_idx, 0);
    chk({tag, "_passed"}, passed_count, 0);
    chk({tag, "_failed"}, failed_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    chk("start_load_req", load_req, 1);
    chk("start_busy", busy, 1);
    chk("start_test_idx", test_idx, 0);
    chk("start_passed", passed_count, 0);
    chk("start_failed", failed_count, 0);
  endtask

  // From the first LOAD cycle to the first RUN cycle.
  task automatic load_and_reset(input int idx, input int ld_delay, input bit poke);
    chk("load_req", load_req, 1);
    chk("load_idx", load_idx, idx);
    chk("load_test_idx", test_idx, idx);
    chk("load_core_reset", core_reset, 1);
    chk("load_core_run", core_run, 0);
    for (int i = 0; i < ld_delay; i++) begin
      if (poke && i == 0) ecall = 1'b1;
      step();
      ecall = 1'b0;
      chk("load_hold_req", load_req, 1);
      chk("load_hold_reset", core_reset, 1);
      chk("load_hold_run", core_run, 0);
      chk("load_hold_valid", result_valid, 0);
    end
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("reset_entry_req", load_req, 0);
    chk("reset_entry_core_reset", core_reset, 1);
    chk("reset_entry_core_run", core_run, 1);
    for (int i = 0; i < RC - 1; i++) begin
      step();
      chk("reset_hold", core_reset, 1);
    end
    step();
    chk("run_entry_core_reset", core_reset, 0);
    chk("run_entry_core_run", core_run, 1);
  endtask

  // From the first RUN cycle through the cycle after RECORD.
  task automatic finish_test(input int idx, input int run_len, input logic [63:0] code, input bit poke);
    for (int i = 0; i < run_len; i++) begin
      if (poke && i == 0) start = 1'b1;
      load_done   = 1'($urandom_range(0, 1));
      status_code = {$urandom, $urandom};
      step();
      start     = 1'b0;
      load_done = 1'b0;
      chk("run_core_run", core_run, 1);
      chk("run_valid", result_valid, 0);
      chk("run_test_idx", test_idx, idx);
    end
    ecall       = 1'b1;
    status_code = code;
    step();
    ecall       = 1'b0;
    status_code = {$urandom, $urandom};
    if (code == 0) exp_pass++;
    else exp_fail++;
    chk("rec_valid", result_valid, 1);
    chk("rec_pass", result_pass, (code == 0) ? 1 : 0);
    chk("rec_code", result_code, code);
    chk("rec_core_run", core_run, 0);
    chk("rec_test_idx", test_idx, idx);
`ifdef DIAGV2_SEQ_TIMEOUT_EN
    chk("rec_timed_out", timed_out, 0);
`endif
    step();
    chk("post_valid", result_valid, 0);
    chk("post_passed", passed_count, exp_pass);
    chk("post_failed", failed_count, exp_fail);
    if (idx == NT - 1) begin
      chk("post_done", done, 1);
      chk("post_busy", busy, 0);
      chk("post_core_reset", core_reset, 1);
    end else begin
      chk("post_load_req", load_req, 1);
      chk("post_next_idx", test_idx, idx + 1);
    end
  endtask

  // mode 0: all pass, fastest; 1: test 1 returns 5; 2: test 0 load delayed 10;
  // 3: fully random
  task automatic campaign(input int mode);
    int ld;
    int rl;
    logic [63:0] code;
    bit poke;
    do_start();
    for (int t = 0; t < NT; t++) begin
      ld = 0; rl = 0; code = 64'd0; poke = 1'b0;
      if (mode == 1 && t == 1) code = 64'd5;
      if (mode == 2) begin
        ld = (t == 0) ? 10 : 1;
        rl = 3;
        poke = 1'b1;
      end
      if (mode == 3) begin
        ld   = $urandom_range(0, 6);
        rl   = $urandom_range(0, 12);
        poke = 1'($urandom_range(0, 1));
        code = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, $urandom};
      end
      load_and_reset(t, ld, poke);
      finish_test(t, rl, code, poke);
    end
    chk("campaign_total", 64'(passed_count) + 64'(failed_count), NT);
    if (mode == 1) begin
      chk("mixed_passed", passed_count, 2);
      chk("mixed_failed", failed_count, 1);
    end
    $display("campaign mode=%0d passed=%0d failed=%0d", mode, passed_count, failed_count);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; ecall = 1'b0; load_done = 1'b0; status_code = '0;
    step();
    step();
    check_reset_vals("por");
    reset_n = 1'b1;
    step();

    // Stray ECALL while idle.
    ecall = 1'b1;
    step();
    ecall = 1'b0;
    chk("ecall_idle_busy", busy, 0);
    chk("ecall_idle_valid", result_valid, 0);

    campaign(0);
    campaign(1);
    campaign(2);
    for (int k = 0; k < 4; k++) campaign(3);

    // Watchdog behaviour: no ECALL ever arrives.
    do_start();
    load_and_reset(0, 1, 1'b0);
`ifdef DIAGV2_SEQ_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("wd_run", core_run, 1);
      chk("wd_valid", result_valid, 0);
    end
    step();
    chk("wd_valid_pulse", result_valid, 1);
    chk("wd_timed_out", timed_out, 1);
    chk("wd_code", result_code, {64{1'b1}});
    chk("wd_pass", result_pass, 0);
    step();
    chk("wd_failed", failed_count, 1);
    chk("wd_passed", passed_count, 0);
    chk("wd_next_load", load_req, 1);
    $display("watchdog test timed_out recorded");
`else
    for (int i = 0; i < 40; i++) begin
      step();
      chk("nowd_run", core_run, 1);
      chk("nowd_valid", result_valid, 0);
    end
    $display("no-watchdog test stayed in RUN");
`endif
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Asynchronous reset in the middle of test 2's RUN.
    do_start();
    load_and_reset(0, 0, 1'b0);
    finish_test(0, 2, 64'd0, 1'b0);
    load_and_reset(1, 1, 1'b0);
    finish_test(1, 1, 64'd9, 1'b0);
    load_and_reset(2, 2, 1'b0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    step();
    reset_n = 1'b1;
    step();
    chk("after_reset_idle", busy, 0);
    $display("mid-run reset abandoned campaign");

    campaign(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
